// File: rtl/redis_cache_pkg.sv
// -----------------------------------------------------------------------------
// redis_cache_pkg
// Shared types and constants for the RedisCache OBI register front-end.
//   cache_op_e     : command opcodes sent to the cache core
//   regif_state_e  : command FSM states
//   *Offset        : register offsets inside the 4 KiB window (addr[11:0])
//   Status*Bit     : bit positions inside the STATUS register
//   sbr_obi_*      : default OBI subordinate request/response structs
//                    (same layout as the croc subordinate OBI bus)
// -----------------------------------------------------------------------------
package redis_cache_pkg;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    GET = 2'd1,
    PUT = 2'd2,
    DEL = 2'd3
  } cache_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } regif_state_e;

  localparam logic [11:0] CtrlOffset     = 12'h000;
  localparam logic [11:0] StatusOffset   = 12'h004;
  localparam logic [11:0] KeyOffset      = 12'h008;
  localparam logic [11:0] ValueInOffset  = 12'h00C;
  localparam logic [11:0] ValueOutOffset = 12'h010;

  localparam int unsigned StatusBusyBit    = 0;
  localparam int unsigned StatusHitBit     = 1;
  localparam int unsigned StatusErrBusyBit = 2;
  localparam int unsigned StatusTimeoutBit = 3;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiIdWidth   = 2;

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [ObiDataWidth/8-1:0] be;
    logic [ObiDataWidth-1:0]   wdata;
    logic [ObiIdWidth-1:0]     aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic [ObiIdWidth-1:0]   rid;
    logic                    err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    sbr_obi_r_chan_t r;
    logic            gnt;
    logic            rvalid;
  } sbr_obi_rsp_t;

endpackage

// File: rtl/redis_cache_cmd_fsm.sv
// -----------------------------------------------------------------------------
// redis_cache_cmd_fsm
// Single-outstanding command sequencer towards the cache core.
// IDLE -> ISSUE (valid/ready handshake) -> WAIT (response or timeout) -> IDLE.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start, start_op        : CTRL write with a non-zero op this cycle
//   key, value             : current KEY / VALUE_IN registers (copied on start)
//   cmd_valid/ready/op/key/value : command channel to the core
//   rsp_valid/hit          : core response strobe and hit flag
//   busy                   : FSM not IDLE
//   hit, err_busy, timeout : STATUS flags
//   value_out_load         : load VALUE_OUT from the core response this cycle
// -----------------------------------------------------------------------------
module redis_cache_cmd_fsm
  import redis_cache_pkg::*;
#(
  parameter int unsigned KeyWidth      = 32,
  parameter int unsigned ValueWidth    = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start,
  input  cache_op_e             start_op,
  input  logic [KeyWidth-1:0]   key,
  input  logic [ValueWidth-1:0] value,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [1:0]            cmd_op,
  output logic [KeyWidth-1:0]   cmd_key,
  output logic [ValueWidth-1:0] cmd_value,
  input  logic                  rsp_valid,
  input  logic                  rsp_hit,
  output logic                  busy,
  output logic                  hit,
  output logic                  err_busy,
  output logic                  timeout,
  output logic                  value_out_load
);

  localparam int unsigned CntWidth = (TimeoutCycles <= 2) ? 1 : $clog2(TimeoutCycles);
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(TimeoutCycles - 1);

  regif_state_e          state_reg, state_next;
  cache_op_e             op_reg, op_next;
  logic [KeyWidth-1:0]   key_reg, key_next;
  logic [ValueWidth-1:0] value_reg, value_next;
  logic [CntWidth-1:0]   cnt_reg, cnt_next;
  logic                  hit_reg, hit_next;
  logic                  err_busy_reg, err_busy_next;
  logic                  timeout_reg, timeout_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      op_reg       <= NOP;
      key_reg      <= '0;
      value_reg    <= '0;
      cnt_reg      <= '0;
      hit_reg      <= 1'b0;
      err_busy_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      key_reg      <= key_next;
      value_reg    <= value_next;
      cnt_reg      <= cnt_next;
      hit_reg      <= hit_next;
      err_busy_reg <= err_busy_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    key_next       = key_reg;
    value_next     = value_reg;
    cnt_next       = cnt_reg;
    hit_next       = hit_reg;
    err_busy_next  = err_busy_reg;
    timeout_next   = timeout_reg;
    value_out_load = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          // Snapshot op/key/value so later register writes cannot disturb
          // the command while it is in flight.
          op_next       = start_op;
          key_next      = key;
          value_next    = value;
          hit_next      = 1'b0;
          err_busy_next = 1'b0;
          timeout_next  = 1'b0;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        if (start) err_busy_next = 1'b1;
        if (cmd_ready) begin
          cnt_next   = CntLoad;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (start) err_busy_next = 1'b1;
        // A response in the last counted cycle still wins over the timeout.
        if (rsp_valid) begin
          hit_next       = rsp_hit;
          value_out_load = (op_reg == GET) && rsp_hit;
          state_next     = IDLE;
        end else if (cnt_reg == '0) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_valid = (state_reg == ISSUE);
  assign cmd_op    = op_reg;
  assign cmd_key   = key_reg;
  assign cmd_value = value_reg;
  assign busy      = (state_reg != IDLE);
  assign hit       = hit_reg;
  assign err_busy  = err_busy_reg;
  assign timeout   = timeout_reg;

endmodule

// File: rtl/redis_cache_obi_regif.sv
// -----------------------------------------------------------------------------
// redis_cache_obi_regif
// OBI subordinate register front-end for the RedisCache core.
// Registers (offset = addr[11:0], word aligned):
//   0x00 CTRL (W, RAZ)  0x04 STATUS (R)  0x08 KEY (RW)
//   0x0C VALUE_IN (RW)  0x10 VALUE_OUT (R)   others: read 0, err=1
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   obi_req_i/obi_rsp_o : OBI subordinate port (gnt=1, rvalid one cycle later)
//   cmd_*               : single command to the cache core
//   rsp_*               : single-cycle response from the cache core
//   busy_o              : command in progress
// -----------------------------------------------------------------------------
module redis_cache_obi_regif
  import redis_cache_pkg::*;
#(
  parameter int unsigned KeyWidth      = 32,
  parameter int unsigned ValueWidth    = 32,
  parameter int unsigned TimeoutCycles = 256,
  parameter type         obi_req_t     = sbr_obi_req_t,
  parameter type         obi_rsp_t     = sbr_obi_rsp_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  obi_req_t              obi_req_i,
  output obi_rsp_t              obi_rsp_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [1:0]            cmd_op_o,
  output logic [KeyWidth-1:0]   cmd_key_o,
  output logic [ValueWidth-1:0] cmd_value_o,
  input  logic                  rsp_valid_i,
  input  logic                  rsp_hit_i,
  input  logic [ValueWidth-1:0] rsp_value_i,
  output logic                  busy_o
);

  logic [9:0]  word;
  logic        is_ctrl, is_status, is_key, is_value_in, is_value_out, is_mapped;
  logic        wr;
  logic [31:0] be_mask;
  logic        start;
  logic        hit, err_busy, timeout, busy;
  logic        value_out_load;
  logic [31:0] status_word;
  logic [31:0] rdata_next;
  logic        err_next;

  logic [KeyWidth-1:0]   key_reg, key_next;
  logic [ValueWidth-1:0] value_in_reg, value_in_next;
  logic [ValueWidth-1:0] value_out_reg, value_out_next;
  obi_rsp_t              rsp_reg;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{obi_req_i.a.addr[31:12], obi_req_i.a.addr[1:0]};

  // Decode on the word index; the byte lane bits do not select a register.
  assign word         = obi_req_i.a.addr[11:2];
  assign is_ctrl      = (word == CtrlOffset[11:2]);
  assign is_status    = (word == StatusOffset[11:2]);
  assign is_key       = (word == KeyOffset[11:2]);
  assign is_value_in  = (word == ValueInOffset[11:2]);
  assign is_value_out = (word == ValueOutOffset[11:2]);
  assign is_mapped    = is_ctrl | is_status | is_key | is_value_in | is_value_out;

  assign wr = obi_req_i.req & obi_req_i.a.we;

  for (genvar gi = 0; gi < 4; gi++) begin : g_be_mask
    assign be_mask[gi*8 +: 8] = {8{obi_req_i.a.be[gi]}};
  end

  // Only byte 0 carries the op field, so CTRL needs be[0].
  assign start = wr & is_ctrl & obi_req_i.a.be[0] & (obi_req_i.a.wdata[1:0] != 2'd0);

  always_comb begin
    key_next       = key_reg;
    value_in_next  = value_in_reg;
    value_out_next = value_out_reg;
    if (wr && is_key) begin
      key_next = KeyWidth'((32'(key_reg) & ~be_mask) | (obi_req_i.a.wdata & be_mask));
    end
    if (wr && is_value_in) begin
      value_in_next = ValueWidth'((32'(value_in_reg) & ~be_mask) | (obi_req_i.a.wdata & be_mask));
    end
    if (value_out_load) value_out_next = rsp_value_i;
  end

  always_comb begin
    status_word                   = '0;
    status_word[StatusBusyBit]    = busy;
    status_word[StatusHitBit]     = hit;
    status_word[StatusErrBusyBit] = err_busy;
    status_word[StatusTimeoutBit] = timeout;
  end

  // Read data is formed from pre-edge state, so a STATUS read that coincides
  // with an FSM transition reports the old state.
  always_comb begin
    rdata_next = '0;
    err_next   = 1'b0;
    if (obi_req_i.req) begin
      err_next = ~is_mapped;
      if (!obi_req_i.a.we) begin
        if (is_status)    rdata_next = status_word;
        if (is_key)       rdata_next = 32'(key_reg);
        if (is_value_in)  rdata_next = 32'(value_in_reg);
        if (is_value_out) rdata_next = 32'(value_out_reg);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_reg       <= '0;
      value_in_reg  <= '0;
      value_out_reg <= '0;
      rsp_reg       <= '0;
    end else begin
      key_reg         <= key_next;
      value_in_reg    <= value_in_next;
      value_out_reg   <= value_out_next;
      rsp_reg.rvalid  <= obi_req_i.req;
      rsp_reg.r.rdata <= rdata_next;
      rsp_reg.r.err   <= err_next;
      rsp_reg.r.rid   <= obi_req_i.a.aid;
    end
  end

  always_comb begin
    obi_rsp_o     = rsp_reg;
    obi_rsp_o.gnt = 1'b1;
  end

  redis_cache_cmd_fsm #(
    .KeyWidth      (KeyWidth),
    .ValueWidth    (ValueWidth),
    .TimeoutCycles (TimeoutCycles)
  ) u_cmd_fsm (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start          (start),
    .start_op       (cache_op_e'(obi_req_i.a.wdata[1:0])),
    .key            (key_reg),
    .value          (value_in_reg),
    .cmd_valid      (cmd_valid_o),
    .cmd_ready      (cmd_ready_i),
    .cmd_op         (cmd_op_o),
    .cmd_key        (cmd_key_o),
    .cmd_value      (cmd_value_o),
    .rsp_valid      (rsp_valid_i),
    .rsp_hit        (rsp_hit_i),
    .busy           (busy),
    .hit            (hit),
    .err_busy       (err_busy),
    .timeout        (timeout),
    .value_out_load (value_out_load)
  );

  assign busy_o = busy;

endmodule

// File: tb/tb_redis_cache_obi_regif.sv
// -----------------------------------------------------------------------------
// tb_redis_cache_obi_regif
// Directed bench for redis_cache_obi_regif with TimeoutCycles=4.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_redis_cache_obi_regif;
  import redis_cache_pkg::*;

  localparam logic [31:0] Base = 32'h2000_1000;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  sbr_obi_req_t obi_req;
  sbr_obi_rsp_t obi_rsp;
  logic         cmd_valid, cmd_ready, rsp_valid, rsp_hit, busy;
  logic [1:0]   cmd_op;
  logic [31:0]  cmd_key, cmd_value, rsp_value;

  int n_total = 0;
  int n_pass  = 0;
  int rise_cnt = 0;
  logic cv_prev = 1'b0;

  redis_cache_obi_regif #(
    .KeyWidth      (32),
    .ValueWidth    (32),
    .TimeoutCycles (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .obi_req_i   (obi_req),
    .obi_rsp_o   (obi_rsp),
    .cmd_valid_o (cmd_valid),
    .cmd_ready_i (cmd_ready),
    .cmd_op_o    (cmd_op),
    .cmd_key_o   (cmd_key),
    .cmd_value_o (cmd_value),
    .rsp_valid_i (rsp_valid),
    .rsp_hit_i   (rsp_hit),
    .rsp_value_i (rsp_value),
    .busy_o      (busy)
  );

  always #5 clk_i = ~clk_i;

  // Counts rising edges of cmd_valid_o (values seen here are pre-edge).
  always @(posedge clk_i) begin
    if (cmd_valid && !cv_prev) rise_cnt++;
    cv_prev = cmd_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic obi_xfer(input string tag, input logic [11:0] off, input logic we,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [1:0] aid, input logic [31:0] exp_rdata,
                          input logic exp_err);
    obi_req.req     = 1'b1;
    obi_req.a.addr  = Base + 32'(off);
    obi_req.a.we    = we;
    obi_req.a.be    = be;
    obi_req.a.wdata = wdata;
    obi_req.a.aid   = aid;
    check({tag, ".gnt"}, 32'(obi_rsp.gnt), 32'd1);
    tick();
    obi_req = '0;
    $display("txn %s %s off=0x%03h be=%b wdata=0x%08h -> rdata=0x%08h err=%0d rid=%0d",
             tag, we ? "WR" : "RD", off, be, wdata, obi_rsp.r.rdata, obi_rsp.r.err, obi_rsp.r.rid);
    check({tag, ".rvalid"}, 32'(obi_rsp.rvalid), 32'd1);
    check({tag, ".rid"}, 32'(obi_rsp.r.rid), 32'(aid));
    check({tag, ".err"}, 32'(obi_rsp.r.err), 32'(exp_err));
    if (!we) check({tag, ".rdata"}, obi_rsp.r.rdata, exp_rdata);
  endtask

  task automatic wr(input string tag, input logic [11:0] off, input logic [31:0] data);
    obi_xfer(tag, off, 1'b1, 4'hF, data, 2'd0, 32'h0, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [11:0] off, input logic [31:0] exp);
    obi_xfer(tag, off, 1'b0, 4'hF, 32'h0, 2'd1, exp, 1'b0);
  endtask

  // From ISSUE: handshake, then one response cycle.
  task automatic finish_cmd(input logic hit, input logic [31:0] value);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_hit   = hit;
    rsp_value = value;
    tick();
    rsp_valid = 1'b0;
    rsp_hit   = 1'b0;
    rsp_value = 32'h0;
  endtask

  initial begin
    int rises;
    obi_req   = '0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_hit   = 1'b0;
    rsp_value = 32'h0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst.rvalid", 32'(obi_rsp.rvalid), 32'd0);
    check("rst.cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.cmd_op", 32'(cmd_op), 32'd0);
    rst_ni = 1'b1;
    tick();
    rd("rst.status", 12'h004, 32'h0);

    // PUT with a stalled core
    wr("put.key", 12'h008, 32'hDEAD_BEEF);
    wr("put.val", 12'h00C, 32'h0000_1234);
    wr("put.ctrl", 12'h000, 32'h2);
    check("put.cmd_valid", 32'(cmd_valid), 32'd1);
    check("put.cmd_op", 32'(cmd_op), 32'd2);
    check("put.cmd_key", cmd_key, 32'hDEAD_BEEF);
    check("put.cmd_value", cmd_value, 32'h0000_1234);
    wr("put.key_busy", 12'h008, 32'h0000_1111);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("put.hold_valid", 32'(cmd_valid), 32'd1);
      check("put.hold_key", cmd_key, 32'hDEAD_BEEF);
      check("put.hold_op", 32'(cmd_op), 32'd2);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("put.wait_valid", 32'(cmd_valid), 32'd0);
    check("put.wait_busy", 32'(busy), 32'd1);
    rsp_valid = 1'b1;
    rsp_hit   = 1'b1;
    tick();
    rsp_valid = 1'b0;
    rsp_hit   = 1'b0;
    check("put.done_busy", 32'(busy), 32'd0);
    rd("put.status", 12'h004, 32'h2);
    rd("put.key_reg", 12'h008, 32'h0000_1111);
    rd("put.vout", 12'h010, 32'h0);

    // GET hit, then GET miss
    wr("get1.ctrl", 12'h000, 32'h1);
    check("get1.cmd_op", 32'(cmd_op), 32'd1);
    finish_cmd(1'b1, 32'h0000_CAFE);
    rd("get1.vout", 12'h010, 32'h0000_CAFE);
    rd("get1.status", 12'h004, 32'h2);
    wr("get2.ctrl", 12'h000, 32'h1);
    finish_cmd(1'b0, 32'h0000_0BAD);
    rd("get2.status", 12'h004, 32'h0);
    rd("get2.vout", 12'h010, 32'h0000_CAFE);

    // Response strobe while IDLE is ignored
    rsp_valid = 1'b1;
    rsp_hit   = 1'b1;
    rsp_value = 32'h7777;
    tick();
    rsp_valid = 1'b0;
    rsp_hit   = 1'b0;
    rsp_value = 32'h0;
    rd("idle_rsp.status", 12'h004, 32'h0);
    rd("idle_rsp.vout", 12'h010, 32'h0000_CAFE);

    // CTRL with be[0]=0 does nothing
    obi_xfer("be0.ctrl", 12'h000, 1'b1, 4'b1110, 32'h0000_0001, 2'd0, 32'h0, 1'b0);
    check("be0.busy", 32'(busy), 32'd0);

    // CTRL while busy sets err_busy and issues no second command
    rises = rise_cnt;
    wr("ebusy.ctrl1", 12'h000, 32'h1);
    wr("ebusy.ctrl2", 12'h000, 32'h1);
    check("ebusy.valid", 32'(cmd_valid), 32'd1);
    finish_cmd(1'b0, 32'h0);
    tick();
    check("ebusy.rises", 32'(rise_cnt - rises), 32'd1);
    check("ebusy.busy", 32'(busy), 32'd0);
    rd("ebusy.status", 12'h004, 32'h4);
    wr("ebusy.ctrl3", 12'h000, 32'h3);
    check("ebusy.del_op", 32'(cmd_op), 32'd3);
    rd("ebusy.cleared", 12'h004, 32'h1);
    finish_cmd(1'b1, 32'h0);
    rd("ebusy.del_status", 12'h004, 32'h2);

    // Timeout: 4 cycles after the handshake edge
    wr("tmo.ctrl", 12'h000, 32'h2);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    rd("tmo.st1", 12'h004, 32'h1);
    rd("tmo.st2", 12'h004, 32'h1);
    rd("tmo.st3", 12'h004, 32'h1);
    check("tmo.busy3", 32'(busy), 32'd1);
    rd("tmo.st4_pre_edge", 12'h004, 32'h1);
    check("tmo.busy4", 32'(busy), 32'd0);
    rd("tmo.status", 12'h004, 32'h8);

    // Unmapped access, byte enables, back-to-back reads
    obi_xfer("unm.rd", 12'h020, 1'b0, 4'hF, 32'h0, 2'd3, 32'h0, 1'b1);
    obi_xfer("unm.wr", 12'h024, 1'b1, 4'hF, 32'hFFFF_FFFF, 2'd2, 32'h0, 1'b1);
    wr("b2b.key", 12'h008, 32'hA5A5_0001);
    wr("b2b.val", 12'h00C, 32'h0000_BEEF);
    obi_xfer("be.key", 12'h008, 1'b1, 4'b0010, 32'hFFFF_FFFF, 2'd0, 32'h0, 1'b0);
    obi_req.req     = 1'b1;
    obi_req.a.addr  = Base + 32'h8;
    obi_req.a.aid   = 2'd1;
    tick();
    obi_req.a.addr  = Base + 32'hC;
    obi_req.a.aid   = 2'd2;
    $display("txn b2b.rd0 RD off=0x008 -> rdata=0x%08h rid=%0d", obi_rsp.r.rdata, obi_rsp.r.rid);
    check("b2b.rvalid0", 32'(obi_rsp.rvalid), 32'd1);
    check("b2b.rdata0", obi_rsp.r.rdata, 32'hA5A5_FF01);
    check("b2b.rid0", 32'(obi_rsp.r.rid), 32'd1);
    tick();
    obi_req = '0;
    $display("txn b2b.rd1 RD off=0x00c -> rdata=0x%08h rid=%0d", obi_rsp.r.rdata, obi_rsp.r.rid);
    check("b2b.rvalid1", 32'(obi_rsp.rvalid), 32'd1);
    check("b2b.rdata1", obi_rsp.r.rdata, 32'h0000_BEEF);
    check("b2b.rid1", 32'(obi_rsp.r.rid), 32'd2);
    tick();
    check("b2b.rvalid_end", 32'(obi_rsp.rvalid), 32'd0);

    // Asynchronous reset mid-command
    wr("arst.ctrl", 12'h000, 32'h1);
    check("arst.valid_before", 32'(cmd_valid), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst.valid", 32'(cmd_valid), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    rd("arst.status", 12'h004, 32'h0);
    rd("arst.key", 12'h008, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
